// File: rtl/bus_pkg.sv
// Shared definitions for the UART sensor bus: responder state encoding,
// the CRC-8 polynomial and the sensor index width.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND_D,
    WAIT_D,
    SEND_C,
    WAIT_C
  } state_t;

  localparam logic [7:0] CRC8_POLY    = 8'h07;
  localparam int         SENSOR_IDX_W = 3;

endpackage

// File: rtl/crc8_byte.sv
// Combinational CRC-8 of one byte: poly CRC8_POLY, init 0, MSB first,
// no reflection, no final XOR. Shared by responder and master checksum paths.
module crc8_byte
  import bus_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] crc
);

  // With a zero init the first XOR reduces to loading the data byte.
  always_comb begin
    crc = data;
    for (int i = 0; i < 8; i++) begin
      crc = crc[7] ? ({crc[6:0], 1'b0} ^ CRC8_POLY) : {crc[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/sensor_responder.sv
// Sensor-node responder: takes a sensor index byte, reads that sensor and
// returns data then CRC-8 over uart_tx. Optional read timeout: RESPONDER_TIMEOUT_EN.
module sensor_responder
  import bus_pkg::*;
#(
`ifdef RESPONDER_TIMEOUT_EN
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] TIMEOUT_CODE   = 8'hEE,
`endif
  parameter int NUM_SENSORS = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  output logic [7:0]              tx_data,
  output logic                    tx_enable,
  input  logic                    tx_active,
  input  logic                    tx_done,
  output logic [SENSOR_IDX_W-1:0] sensor_sel,
  output logic                    sensor_req,
  input  logic [7:0]              sensor_data,
  input  logic                    sensor_valid,
  output logic                    busy,
  output logic                    err
);

  state_t                  state, state_next;
  logic [SENSOR_IDX_W-1:0] idx;
  logic                    idx_ok;
  logic                    accept;
  logic                    capture;
  logic                    expire;
  logic [7:0]              crc_in, crc_out, crc_hold;
  logic                    unused_bits;

  assign idx         = rx_data[SENSOR_IDX_W-1:0];
  assign unused_bits = ^rx_data[7:SENSOR_IDX_W];
  assign idx_ok      = (idx != '0) && (int'(idx) <= NUM_SENSORS);
  assign accept      = (state == IDLE) && rx_done && idx_ok;

`ifdef RESPONDER_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // A real sensor answer in the expiry cycle takes priority over the timeout.
  assign expire = (state == READ) && !sensor_valid &&
                  (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign crc_in = sensor_valid ? sensor_data : TIMEOUT_CODE;

  always_ff @(posedge clock) begin
    if (reset || state != READ) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 16'd1;
  end
`else
  assign expire = 1'b0;
  assign crc_in = sensor_data;
`endif

  assign capture = (state == READ) && (sensor_valid || expire);

  crc8_byte u_crc (
    .data (crc_in),
    .crc  (crc_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_data    <= '0;
      sensor_sel <= '0;
      crc_hold   <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_next;
      err   <= (rx_done && (state != IDLE || !idx_ok)) || expire;
      if (accept) sensor_sel <= idx;
      if (capture) begin
        tx_data  <= crc_in;
        crc_hold <= crc_out;
      end
      if (state == WAIT_D && tx_done) tx_data <= crc_hold;
    end
  end

  // Send states wait out any byte uart_tx is still shifting before pulsing.
  always_comb begin
    state_next = state;
    tx_enable  = 1'b0;
    sensor_req = (state == READ);
    busy       = (state != IDLE);
    case (state)
      IDLE:   if (accept) state_next = READ;
      READ:   if (capture) state_next = SEND_D;
      SEND_D: if (!tx_active) begin
                tx_enable  = 1'b1;
                state_next = WAIT_D;
              end
      WAIT_D: if (tx_done) state_next = SEND_C;
      SEND_C: if (!tx_active) begin
                tx_enable  = 1'b1;
                state_next = WAIT_C;
              end
      WAIT_C: if (tx_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sensor_responder.sv
// Directed bench for sensor_responder with behavioural sensor and uart_tx models.
// The timeout scenario runs only when RESPONDER_TIMEOUT_EN is defined.
module tb_sensor_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic [2:0] sensor_sel;
  logic       sensor_req;
  logic [7:0] sensor_data = 8'h00;
  logic       sensor_valid = 1'b0;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;

  // Sensor model controls (written by tasks only)
  logic       sensor_en = 1'b0;
  int         sensor_delay = 0;
  logic [7:0] sensor_value = 8'h00;
  int         clear_req = 0;

  // Model-owned state
  int         s_cnt = 0;
  int         tx_cnt = 0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_last = 8'h00;
  logic [7:0] tx_bytes[$];
  int         err_count = 0;
  int         req_cycles = 0;
  int         clear_ack = 0;

  sensor_responder #(
`ifdef RESPONDER_TIMEOUT_EN
    .TIMEOUT_CYCLES(10),
    .TIMEOUT_CODE(8'hEE),
`endif
    .NUM_SENSORS(6)
  ) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_enable(tx_enable), .tx_active(tx_active), .tx_done(tx_done),
    .sensor_sel(sensor_sel), .sensor_req(sensor_req), .sensor_data(sensor_data),
    .sensor_valid(sensor_valid), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // Sensor answers sensor_delay cycles into a request with sensor_value.
  always @(negedge clock) begin
    if (sensor_req && sensor_en && !sensor_valid) begin
      if (s_cnt == sensor_delay) begin
        sensor_valid = 1'b1;
        sensor_data  = sensor_value;
        s_cnt = 0;
      end else begin
        s_cnt++;
      end
    end else begin
      sensor_valid = 1'b0;
      if (!sensor_req) s_cnt = 0;
    end
  end

  // uart_tx model: records each started byte, shifts for 4 cycles, pulses tx_done.
  always @(negedge clock) begin
    tx_done = 1'b0;
    if (clear_ack != clear_req) begin
      clear_ack = clear_req;
      tx_cnt    = 0;
      tx_start  = 1'b0;
      tx_active = 1'b0;
    end else if (tx_start) begin
      tx_start  = 1'b0;
      tx_active = 1'b1;
      tx_cnt    = 4;
    end else if (tx_cnt > 0) begin
      checks++;
      if (tx_data !== tx_last) begin
        failures++;
        $display("[TB] FAIL tx_hold: tx_data=%02h expected %02h", tx_data, tx_last);
      end
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_active = 1'b0;
        tx_done   = 1'b1;
      end
    end
    if (tx_enable) begin
      checks++;
      if (tx_active !== 1'b0) begin
        failures++;
        $display("[TB] FAIL tx_overlap: tx_enable while tx_active=%b expected 0", tx_active);
      end
      tx_bytes.push_back(tx_data);
      tx_last  = tx_data;
      tx_start = 1'b1;
    end
    if (err) err_count++;
    if (sensor_req) req_cycles++;
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clock);
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_idle: busy=%b after %0d cycles expected 0", name, busy, n);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx_data, tx_enable, sensor_sel, sensor_req, busy, err} !== 15'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: data=%02h en=%b sel=%0d req=%b busy=%b err=%b expected all 0",
               tx_data, tx_enable, sensor_sel, sensor_req, busy, err);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_read(input string name, input logic [7:0] req, input logic [2:0] sel,
                           input logic [7:0] val, input logic [7:0] crc, input int dly);
    int base = tx_bytes.size();
    int e0 = err_count;
    logic sel_bad = 1'b0;
    sensor_en = 1'b1;
    sensor_delay = dly;
    sensor_value = val;
    applyStimulus(req);
    checks++;
    if (busy !== 1'b1 || sensor_req !== 1'b1 || sensor_sel !== sel) begin
      failures++;
      $display("[TB] FAIL %s_start: busy=%b req=%b sel=%0d expected 1 1 %0d",
               name, busy, sensor_req, sensor_sel, sel);
    end
    for (int i = 0; i < 400 && busy; i++) begin
      @(negedge clock);
      if (busy && sensor_sel !== sel) sel_bad = 1'b1;
    end
    wait_idle(name);
    checks++;
    if (sel_bad) begin
      failures++;
      $display("[TB] FAIL %s_sel_hold: sensor_sel changed, expected %0d", name, sel);
    end
    checks++;
    if (tx_bytes.size() != base + 2) begin
      failures++;
      $display("[TB] FAIL %s_count: %0d bytes expected 2", name, tx_bytes.size() - base);
    end else begin
      checks++;
      if (tx_bytes[base] !== val || tx_bytes[base+1] !== crc) begin
        failures++;
        $display("[TB] FAIL %s_bytes: got %02h %02h expected %02h %02h",
                 name, tx_bytes[base], tx_bytes[base+1], val, crc);
      end
    end
    checks++;
    if (err_count != e0) begin
      failures++;
      $display("[TB] FAIL %s_err: %0d err cycles expected 0", name, err_count - e0);
    end
  endtask

  task automatic test_invalid();
    int base = tx_bytes.size();
    int e0 = err_count;
    int r0 = req_cycles;
    logic [7:0] bad[2] = '{8'h00, 8'h07};
    foreach (bad[i]) begin
      applyStimulus(bad[i]);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || sensor_req !== 1'b0) begin
        failures++;
        $display("[TB] FAIL invalid_%02h: err=%b busy=%b req=%b expected 1 0 0",
                 bad[i], err, busy, sensor_req);
      end
    end
    repeat (6) @(negedge clock);
    checks++;
    if (err_count - e0 != 2 || req_cycles != r0 || tx_bytes.size() != base) begin
      failures++;
      $display("[TB] FAIL invalid_effects: err=%0d req=%0d tx=%0d expected 2 0 0",
               err_count - e0, req_cycles - r0, tx_bytes.size() - base);
    end
  endtask

  task automatic test_overrun();
    int base = tx_bytes.size();
    int e0 = err_count;
    int n = 0;
    sensor_en = 1'b1;
    sensor_delay = 1;
    sensor_value = 8'h02;
    applyStimulus(8'h05);
    while (!tx_active && n < 100) begin
      @(negedge clock);
      n++;
    end
    applyStimulus(8'h04);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || sensor_sel !== 3'd5) begin
      failures++;
      $display("[TB] FAIL overrun_err: err=%b busy=%b sel=%0d expected 1 1 5", err, busy, sensor_sel);
    end
    @(negedge clock);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_width: err=%b expected 0", err);
    end
    wait_idle("overrun");
    checks++;
    if (tx_bytes.size() != base + 2 || err_count - e0 != 1) begin
      failures++;
      $display("[TB] FAIL overrun_count: tx=%0d err=%0d expected 2 1", tx_bytes.size() - base, err_count - e0);
    end else begin
      checks++;
      if (tx_bytes[base] !== 8'h02 || tx_bytes[base+1] !== 8'h0E) begin
        failures++;
        $display("[TB] FAIL overrun_bytes: got %02h %02h expected 02 0e", tx_bytes[base], tx_bytes[base+1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sensor_en = 1'b1;
    sensor_delay = 0;
    sensor_value = 8'h80;
    applyStimulus(8'h06);
    @(negedge clock);
    checks++;
    if (tx_enable !== 1'b1 || tx_data !== 8'h80 || sensor_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL min_latency: en=%b data=%02h req=%b expected 1 80 0", tx_enable, tx_data, sensor_req);
    end
    wait_idle("min_latency");
  endtask

  task automatic test_reset_mid();
    int base = tx_bytes.size();
    int n = 0;
    sensor_en = 1'b1;
    sensor_delay = 1;
    sensor_value = 8'h01;
    applyStimulus(8'h01);
    while (tx_bytes.size() < base + 2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({tx_data, tx_enable, sensor_sel, sensor_req, busy, err} !== 15'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid: data=%02h en=%b sel=%0d req=%b busy=%b err=%b expected all 0",
               tx_data, tx_enable, sensor_sel, sensor_req, busy, err);
    end
    reset = 1'b0;
    clear_req++;
    repeat (8) @(negedge clock);
    checks++;
    if (tx_bytes.size() != base + 2) begin
      failures++;
      $display("[TB] FAIL reset_reissue: %0d bytes expected 2", tx_bytes.size() - base);
    end
    test_read("after_reset", 8'h02, 3'd2, 8'h02, 8'h0E, 1);
  endtask

`ifdef RESPONDER_TIMEOUT_EN
  task automatic test_timeout();
    int base = tx_bytes.size();
    int e0 = err_count;
    int n = 1;
    sensor_en = 1'b0;
    applyStimulus(8'h04);
    while (!err && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n != 11) begin
      failures++;
      $display("[TB] FAIL timeout_when: err at cycle %0d expected 11", n);
    end
    wait_idle("timeout");
    checks++;
    if (tx_bytes.size() != base + 2 || err_count - e0 != 1) begin
      failures++;
      $display("[TB] FAIL timeout_count: tx=%0d err=%0d expected 2 1", tx_bytes.size() - base, err_count - e0);
    end else begin
      checks++;
      if (tx_bytes[base] !== 8'hEE || tx_bytes[base+1] !== 8'h84) begin
        failures++;
        $display("[TB] FAIL timeout_bytes: got %02h %02h expected ee 84", tx_bytes[base], tx_bytes[base+1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read("basic", 8'h01, 3'd1, 8'h01, 8'h07, 3);
    test_read("high_bits", 8'hFB, 3'd3, 8'h80, 8'h89, 2);
    test_invalid();
    test_overrun();
    test_back_to_back();
`ifdef RESPONDER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
